// File: rtl/lsu_dtag_pkg.sv
// Shared constants, log-FSM state type and chunk-count helper for the L1D tag parity checker.
package lsu_dtag_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic {
    LOG_IDLE   = 1'b0,
    LOG_LOGGED = 1'b1
  } log_state_t;

  function automatic int chunk_cnt(input int bits);
    return (bits + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/lsu_dtag_way_par.sv
// Single-way parity generator: one XOR reduction per 8-bit chunk, the last chunk partial.
module lsu_dtag_way_par
  import lsu_dtag_pkg::*;
#(
  parameter int BITS = 30
) (
  input  logic [BITS-1:0]             data,
  output logic [chunk_cnt(BITS)-1:0]  chunk_par
);

  localparam int NCH = chunk_cnt(BITS);

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    localparam int LO = c * CHUNK_W;
    localparam int CW = ((BITS - LO) < CHUNK_W) ? (BITS - LO) : CHUNK_W;
    assign chunk_par[c] = ^data[LO +: CW];
  end

endmodule

// File: rtl/lsu_dtag_pchk.sv
// L1D tag parity checker (M -> G), diagnostic tag read (M -> G -> W2) and error log.
// Optional error injection on the parity bit is enabled by defining LSU_DTAG_ERR_INJ_EN.
module lsu_dtag_pchk
  import lsu_dtag_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int TAG_W  = 29,
  parameter int WAY_IW = $clog2(WAYS)
) (
  input  logic                       rclk,
  input  logic                       reset,
  input  logic [WAYS*(TAG_W+1)-1:0]  dtag_rdata_m,
  input  logic [WAYS-1:0]            dva_vld_m,
  input  logic                       tag_rd_vld_m,
  input  logic [WAYS-1:0]            lsu_dtag_rsel_m,
  input  logic                       diag_rd_req_m,
  input  logic                       err_log_clr,
`ifdef LSU_DTAG_ERR_INJ_EN
  input  logic                       err_inj_en,
  input  logic [WAYS-1:0]            err_inj_way,
`endif
  output logic [WAYS-1:0]            lsu_rd_dtag_parity_g,
  output logic                       lsu_dtag_perr_vld_g,
  output logic [TAG_W+1:0]           diag_rdata_w2,
  output logic                       diag_rdata_vld_w2,
  output logic                       err_log_vld,
  output logic [WAY_IW-1:0]          err_log_way,
  output logic [TAG_W:0]             err_log_tag,
  output logic                       err_log_multi,
  output logic [7:0]                 err_cnt
);

  localparam int SLICE_W = TAG_W + 1;
  localparam int NCH     = chunk_cnt(SLICE_W);

  logic [SLICE_W-1:0] slice_m  [WAYS];
  logic [SLICE_W-1:0] par_in_m [WAYS];
  logic [NCH-1:0]     chunk_m  [WAYS];
  logic [TAG_W+1:0]   diag_m;

  logic [NCH-1:0]     chunk_g  [WAYS];
  logic [SLICE_W-1:0] slice_g  [WAYS];
  logic [WAYS-1:0]    vld_g;
  logic               tag_rd_vld_g;
  logic [TAG_W+1:0]   diag_g;
  logic               diag_vld_g;

  log_state_t         state, nxt_state;
  logic               cap, set_multi;
  logic [WAY_IW-1:0]  low_way;
  logic [SLICE_W-1:0] low_tag;

  // ---- M stage: slice, optional injection, chunk parity, diagnostic select
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      slice_m[w]  = dtag_rdata_m[w*SLICE_W +: SLICE_W];
      par_in_m[w] = slice_m[w];
`ifdef LSU_DTAG_ERR_INJ_EN
      par_in_m[w][TAG_W] = slice_m[w][TAG_W] ^ (err_inj_en & tag_rd_vld_m & err_inj_way[w]);
`endif
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    lsu_dtag_way_par #(.BITS(SLICE_W)) u_par (
      .data      (par_in_m[w]),
      .chunk_par (chunk_m[w])
    );
  end

  // Lowest selected way wins when the select is not one-hot.
  always_comb begin
    diag_m = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lsu_dtag_rsel_m[w]) diag_m = {slice_m[w], dva_vld_m[w]};
    end
  end

  // ---- M -> G
  always_ff @(posedge rclk) begin
    if (reset) begin
      for (int w = 0; w < WAYS; w++) begin
        chunk_g[w] <= '0;
        slice_g[w] <= '0;
      end
      vld_g        <= '0;
      tag_rd_vld_g <= 1'b0;
      diag_g       <= '0;
      diag_vld_g   <= 1'b0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        chunk_g[w] <= chunk_m[w];
        slice_g[w] <= slice_m[w];
      end
      vld_g        <= dva_vld_m;
      tag_rd_vld_g <= tag_rd_vld_m;
      diag_g       <= diag_m;
      diag_vld_g   <= diag_rd_req_m;
    end
  end

  // ---- G stage: parity check and lowest erring way
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      lsu_rd_dtag_parity_g[w] = (^chunk_g[w]) & vld_g[w] & tag_rd_vld_g;
    end
  end

  assign lsu_dtag_perr_vld_g = |lsu_rd_dtag_parity_g;

  always_comb begin
    low_way = '0;
    low_tag = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lsu_rd_dtag_parity_g[w]) begin
        low_way = WAY_IW'(w);
        low_tag = slice_g[w];
      end
    end
  end

  // ---- G -> W2
  always_ff @(posedge rclk) begin
    if (reset) begin
      diag_rdata_w2     <= '0;
      diag_rdata_vld_w2 <= 1'b0;
    end else begin
      diag_rdata_w2     <= diag_g;
      diag_rdata_vld_w2 <= diag_vld_g;
    end
  end

  // ---- Error log FSM
  always_comb begin
    nxt_state = state;
    cap       = 1'b0;
    set_multi = 1'b0;
    if (err_log_clr) begin
      nxt_state = lsu_dtag_perr_vld_g ? LOG_LOGGED : LOG_IDLE;
      cap       = lsu_dtag_perr_vld_g;
    end else begin
      case (state)
        LOG_IDLE: begin
          if (lsu_dtag_perr_vld_g) begin
            nxt_state = LOG_LOGGED;
            cap       = 1'b1;
          end
        end
        LOG_LOGGED: set_multi = lsu_dtag_perr_vld_g;
        default:    nxt_state = LOG_IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state         <= LOG_IDLE;
      err_log_way   <= '0;
      err_log_tag   <= '0;
      err_log_multi <= 1'b0;
      err_cnt       <= 8'd0;
    end else begin
      state <= nxt_state;
      if (cap) begin
        err_log_way <= low_way;
        err_log_tag <= low_tag;
      end
      if (err_log_clr)    err_log_multi <= 1'b0;
      else if (set_multi) err_log_multi <= 1'b1;
      if (err_log_clr)
        err_cnt <= lsu_dtag_perr_vld_g ? 8'd1 : 8'd0;
      else if (lsu_dtag_perr_vld_g && err_cnt != 8'd255)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_log_vld = (state == LOG_LOGGED);

endmodule

// File: doc/lsu_dtag_pchk.md
LSU_DTAG_PCHK -- requirements
Module: lsu_dtag_pchk

Interface
REQ-001 SHALL have parameter WAYS, default 4: number of L1D ways (2..16).
REQ-002 SHALL have parameter TAG_W, default 29: tag bits per way, excluding the parity bit.
REQ-003 SHALL have parameter WAY_IW, default $clog2(WAYS): way-index width.
REQ-004 SHALL have port rclk  in  1  clock; one clock, all flops on its rising edge.
REQ-005 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port dtag_rdata_m  in  WAYS*(TAG_W+1)  tag array read data; way w occupies [w*(TAG_W+1) +: TAG_W+1], and the MSB of each slice is parity.
REQ-007 SHALL have port dva_vld_m  in  WAYS  valid-array bits.
REQ-008 SHALL have port tag_rd_vld_m  in  1  qualifies a tag lookup in M.
REQ-009 SHALL have port lsu_dtag_rsel_m  in  WAYS  diagnostic way select, one-hot.
REQ-010 SHALL have port diag_rd_req_m  in  1  diagnostic tag read request.
REQ-011 SHALL have port err_log_clr  in  1  clears the error log and the error counter.
REQ-012 SHALL have port lsu_rd_dtag_parity_g  out  WAYS  per-way parity error, G stage.
REQ-013 SHALL have port lsu_dtag_perr_vld_g  out  1  any qualified parity error in G.
REQ-014 SHALL have port diag_rdata_w2  out  TAG_W+2  {parity, tag, valid} of the selected way.
REQ-015 SHALL have port diag_rdata_vld_w2  out  1  qualifies diag_rdata_w2.
REQ-016 SHALL have port err_log_vld  out  1  the log holds an error.
REQ-017 SHALL have port err_log_way  out  WAY_IW  way index of the logged error.
REQ-018 SHALL have port err_log_tag  out  TAG_W+1  raw tag and parity of the logged way.
REQ-019 SHALL have port err_log_multi  out  1  a further error occurred while the log was held.
REQ-020 SHALL have port err_cnt  out  8  saturating count of error cycles.

Function
REQ-021 SHALL compute per-way parity in M as an 8-bit-chunk XOR tree over all TAG_W+1 bits; the last chunk is partial.
REQ-022 SHALL flop the chunk parities, dva_vld_m and tag_rd_vld_m into G; a way's error is the XOR of its chunks being 1 (even parity).
REQ-023 SHALL drive lsu_rd_dtag_parity_g[w] = parity_err[w] & vld_g[w] & tag_rd_vld_g, giving 1-cycle latency from M.
REQ-024 SHALL assert lsu_dtag_perr_vld_g as the OR of lsu_rd_dtag_parity_g.
REQ-025 SHALL treat diagnostic select as priority lowest-index-first when not one-hot; all-zero select yields data 0.
REQ-026 SHALL flop the selected {parity, tag, valid} into G and then W2, asserting diag_rdata_vld_w2 2 cycles after diag_rd_req_m.
REQ-027 SHALL implement a log FSM with states IDLE and LOGGED.
REQ-028 In IDLE, on lsu_dtag_perr_vld_g, SHALL capture the lowest erring way index and that way's raw G-stage tag, then enter LOGGED.
REQ-029 In LOGGED, on a further error, SHALL set err_log_multi and SHALL NOT overwrite the way or tag.
REQ-030 On err_log_clr, SHALL return to IDLE and clear vld, multi and err_cnt.
REQ-031 On err_log_clr together with an error, SHALL capture the new error, enter LOGGED with multi=0, and set err_cnt=1.
REQ-032 SHALL increment err_cnt by 1 per cycle with lsu_dtag_perr_vld_g, regardless of the number of ways in error; it saturates at 255 and does not wrap.

Reset
REQ-033 SHALL clear on reset: every pipeline flop, every output to 0, and the FSM to IDLE.
REQ-034 SHALL discard M/G errors in flight when reset is asserted; no log capture occurs in the reset cycle or the cycle after.

Configuration
REQ-035 With LSU_DTAG_ERR_INJ_EN defined, SHALL add inputs err_inj_en (1) and err_inj_way (WAYS); the parity bit of each masked way is inverted in M before the check, for qualified lookups only.
REQ-036 Without LSU_DTAG_ERR_INJ_EN, those ports and their logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-037 SHALL place the chunk width constant (8), the log state enum, and the chunk-count helper in shared package lsu_dtag_pkg.
REQ-038 SHALL use sub-module lsu_dtag_way_par (single-way chunked parity generator), instantiated WAYS times by generate.

Verification
REQ-039 Bench SHALL cover: WAYS=4, all ways with correct parity, tag_rd_vld_m=1 -> lsu_rd_dtag_parity_g=0, err_cnt=0.
REQ-040 Bench SHALL cover: way2 parity flipped, dva_vld_m=4'b0100 -> next cycle parity_g=4'b0100; log way=2, vld=1, err_cnt=1.
REQ-041 Bench SHALL cover: ways 1 and 3 in error in the same cycle, then way0 in error -> way=1, multi=1, err_cnt=2.
REQ-042 Bench SHALL cover: err_log_clr coinciding with a way3 error -> LOGGED, way=3, multi=0, err_cnt=1; 300 consecutive error cycles -> err_cnt=255.
REQ-043 Bench SHALL cover: diag_rd_req_m with rsel=4'b0110 -> diag_rdata_w2 equals way1's {parity, tag, valid} 2 cycles later, with vld_w2=1.
REQ-044 Bench SHALL cover: with LSU_DTAG_ERR_INJ_EN, err_inj_way=4'b1000 on clean data -> parity_g[3]=1; reset during LOGGED -> all outputs 0 the next cycle.
